filter_scratchpad_loader: RTL and testbench

Filter-load stage of the PE.
- Accepts filter words from the upstream filter stream over a valid/ready handshake and writes them sequentially into a DEPTH-entry filter scratchpad.
- Signals load completion to the controller.
- Serves registered random-access reads to the downstream MAC datapath.
- Sits between the filter input buffer and the PE compute pipeline.

---
 rtl/filter_scratchpad_loader_if.sv | 27 ++
 rtl/filter_scratchpad_loader.sv | 88 ++++++++
 tb/tb_filter_scratchpad_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_scratchpad_loader_if.sv
// Filter stream, load control/status and scratchpad read port of the PE filter-load stage.
interface filter_scratchpad_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
);
    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  busy;
    logic                  load_done;

    modport master (
        output start, in_valid, in_data, rd_en, rd_addr,
        input  in_ready, rd_data, rd_valid, word_count, busy, load_done
    );

    modport slave (
        input  start, in_valid, in_data, rd_en, rd_addr,
        output in_ready, rd_data, rd_valid, word_count, busy, load_done
    );
endinterface

// File: rtl/filter_scratchpad_loader.sv
// Loads DEPTH filter words from a valid/ready stream into a scratchpad and
// serves registered random-access reads to the MAC datapath.
module filter_scratchpad_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 25,
    parameter int ADDR_WIDTH = 5
) (
    input logic                     clk,
    input logic                     rst,
    filter_scratchpad_loader_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   word_count_q;
    logic                  busy_q;
    logic                  load_done_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    function automatic logic [ADDR_WIDTH:0] sat_inc(input logic [ADDR_WIDTH:0] v);
        return (v >= DEPTH_CNT) ? DEPTH_CNT : v + (ADDR_WIDTH + 1)'(1);
    endfunction

    // Load FSM and scratchpad write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            word_count_q <= '0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state        <= LOAD;
                        wr_ptr       <= '0;
                        word_count_q <= '0;
                        busy_q       <= 1'b1;
                        load_done_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        mem[wr_ptr]  <= bus.in_data;
                        word_count_q <= sat_inc(word_count_q);
                        if (wr_ptr == LAST_ADDR) begin
                            state       <= DONE;
                            busy_q      <= 1'b0;
                            load_done_q <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read port: one-cycle latency, old data on same-address collision
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en)
                rd_data_q <= ({1'b0, bus.rd_addr} < DEPTH_CNT) ? mem[bus.rd_addr] : '0;
        end
    end

    assign bus.in_ready   = (state == LOAD);
    assign bus.busy       = busy_q;
    assign bus.load_done  = load_done_q;
    assign bus.word_count = word_count_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_filter_scratchpad_loader.sv
// Scoreboard bench for filter_scratchpad_loader: load, stall, overflow, readback, reload, reset.
module tb_filter_scratchpad_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  filter_scratchpad_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) bus();

  filter_scratchpad_loader #(.DATA_WIDTH(16), .DEPTH(25), .ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = IDLE, 1 = LOAD, 2 = DONE
  logic [15:0] mdl [32];
  int          mst, mptr, mcnt;
  logic [15:0] sbq [$];
  logic [15:0] last_rd;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 16'h0;
    mst = 0; mptr = 0; mcnt = 0;
    sbq.delete();
    last_rd = 16'h0;
  endtask

  task automatic step();
    logic        exp_rv;
    logic [15:0] e;
    exp_rv = rst && bus.rd_en;
    if (!rst) begin
      model_reset();
    end else begin
      if (bus.rd_en) sbq.push_back((bus.rd_addr < 5'd25) ? mdl[bus.rd_addr] : 16'h0);
      if (mst == 1) begin
        if (bus.in_valid) begin
          mdl[mptr] = bus.in_data;
          mcnt++;
          if (mptr == 24) mst = 2; else mptr++;
        end
      end else if (bus.start) begin
        mst = 1; mptr = 0; mcnt = 0;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rd_valid !== exp_rv) begin
      errors++; $display("FAIL rd_valid: got %b expected %b", bus.rd_valid, exp_rv);
    end
    if (exp_rv && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (bus.rd_data !== e) begin
        errors++; $display("FAIL sb_rd_data: got %h expected %h", bus.rd_data, e);
      end
      last_rd = e;
    end else begin
      checks++;
      if (bus.rd_data !== last_rd) begin
        errors++; $display("FAIL rd_data_hold: got %h expected %h", bus.rd_data, last_rd);
      end
    end
    checks += 4;
    if (bus.in_ready !== (mst == 1)) begin
      errors++; $display("FAIL in_ready: got %b expected %b", bus.in_ready, (mst == 1));
    end
    if (bus.busy !== (mst == 1)) begin
      errors++; $display("FAIL busy: got %b expected %b", bus.busy, (mst == 1));
    end
    if (bus.load_done !== (mst == 2)) begin
      errors++; $display("FAIL load_done: got %b expected %b", bus.load_done, (mst == 2));
    end
    if (bus.word_count !== 6'(mcnt)) begin
      errors++; $display("FAIL word_count: got %0d expected %0d", bus.word_count, mcnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 16'h0;
    bus.rd_en = 1'b0; bus.rd_addr = 5'd0;
    model_reset();
    repeat (3) step();
    checks++;
    if ({bus.in_ready, bus.busy, bus.load_done, bus.rd_valid} !== 4'b0 ||
        bus.word_count !== 6'd0 || bus.rd_data !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: got rdy%b busy%b done%b rv%b wc%0d rd%h expected all 0",
                          bus.in_ready, bus.busy, bus.load_done, bus.rd_valid, bus.word_count, bus.rd_data);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_full_load();
    int rdy = 0;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (bus.in_ready === 1'b1) rdy++;
      bus.in_valid = 1'b1; bus.in_data = 16'h0100 + 16'(i);
      step();
    end
    checks++;
    if (rdy != 25) begin
      errors++; $display("FAIL full_ready_cycles: got %0d expected 25", rdy);
    end
    checks++;
    if (bus.load_done !== 1'b1 || bus.word_count !== 6'd25) begin
      errors++; $display("FAIL full_done: got done%b wc%0d expected done1 wc25", bus.load_done, bus.word_count);
    end
    bus.in_data = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.in_ready !== 1'b0 || bus.word_count !== 6'd25) begin
        errors++; $display("FAIL full_after: got rdy%b wc%0d expected rdy0 wc25", bus.in_ready, bus.word_count);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_readback();
    for (int a = 0; a < 25; a++) begin
      bus.rd_en = 1'b1; bus.rd_addr = 5'(a);
      step();
      checks++;
      if (bus.rd_data !== 16'h0100 + 16'(a) || bus.rd_valid !== 1'b1) begin
        errors++; $display("FAIL readback_%0d: got %h v%b expected %h v1", a, bus.rd_data, bus.rd_valid, 16'h0100 + 16'(a));
      end
    end
    bus.rd_addr = 5'd27;
    step();
    checks++;
    if (bus.rd_data !== 16'h0000 || bus.rd_valid !== 1'b1) begin
      errors++; $display("FAIL readback_oob: got %h v%b expected 0000 v1", bus.rd_data, bus.rd_valid);
    end
    bus.rd_en = 1'b0;
    step();
  endtask

  task automatic test_reload_collision();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    checks++;
    if (bus.word_count !== 6'd0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reload_start: got wc%0d rdy%b expected wc0 rdy1", bus.word_count, bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.in_data = 16'hBEEF;
    bus.rd_en = 1'b1; bus.rd_addr = 5'd0;
    step();
    checks++;
    if (bus.rd_data !== 16'h0100 || bus.word_count !== 6'd1) begin
      errors++; $display("FAIL collision_old: got %h wc%0d expected 0100 wc1", bus.rd_data, bus.word_count);
    end
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.rd_data !== 16'hBEEF) begin
      errors++; $display("FAIL collision_new: got %h expected beef", bus.rd_data);
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'h0400 + 16'(i);
      step();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.word_count !== 6'd10) begin
      errors++; $display("FAIL midload_count: got %0d expected 10", bus.word_count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.busy, bus.load_done, bus.rd_valid} !== 4'b0 ||
        bus.word_count !== 6'd0 || bus.rd_data !== 16'h0) begin
      errors++; $display("FAIL async_reset: got rdy%b busy%b done%b rv%b wc%0d rd%h expected all 0",
                          bus.in_ready, bus.busy, bus.load_done, bus.rd_valid, bus.word_count, bus.rd_data);
    end
    model_reset();
    step();
    rst = 1'b1;
    bus.rd_en = 1'b1; bus.rd_addr = 5'd3;
    step();
    checks++;
    if (bus.rd_data !== 16'h0 || bus.rd_valid !== 1'b1) begin
      errors++; $display("FAIL reset_cleared: got %h v%b expected 0000 v1", bus.rd_data, bus.rd_valid);
    end
    bus.rd_en = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.in_ready !== 1'b0 || bus.word_count !== 6'd0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL idle_needs_start: got rdy%b wc%0d busy%b expected 0 0 0", bus.in_ready, bus.word_count, bus.busy);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_stalled();
    int writes = 0;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      bus.in_valid = (k % 2 == 0);
      bus.in_data  = 16'h0200 + 16'(k / 2);
      bus.start    = (k == 10);
      if (bus.in_valid && bus.in_ready) writes++;
      step();
    end
    bus.in_valid = 1'b0; bus.start = 1'b0;
    checks++;
    if (writes != 25 || bus.load_done !== 1'b1 || bus.word_count !== 6'd25) begin
      errors++; $display("FAIL stalled_load: got w%0d done%b wc%0d expected w25 done1 wc25", writes, bus.load_done, bus.word_count);
    end
    bus.rd_en = 1'b1; bus.rd_addr = 5'd12;
    step();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_data !== 16'h020C) begin
      errors++; $display("FAIL stalled_read: got %h expected 020c", bus.rd_data);
    end
  endtask

  task automatic test_overflow();
    int acc = 0;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.in_ready === 1'b1) acc++;
      bus.in_valid = 1'b1; bus.in_data = 16'h0300 + 16'(i);
      step();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (acc != 25 || bus.word_count !== 6'd25) begin
      errors++; $display("FAIL overflow_accept: got acc%0d wc%0d expected 25 25", acc, bus.word_count);
    end
    bus.rd_en = 1'b1; bus.rd_addr = 5'd24;
    step();
    checks++;
    if (bus.rd_data !== 16'h0318) begin
      errors++; $display("FAIL overflow_last: got %h expected 0318", bus.rd_data);
    end
    bus.rd_addr = 5'd25;
    step();
    checks++;
    if (bus.rd_data !== 16'h0000) begin
      errors++; $display("FAIL overflow_beyond: got %h expected 0000", bus.rd_data);
    end
    bus.rd_en = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_readback();
    test_reload_collision();
    test_reset_midload();
    test_stalled();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
